reg_file_2r1w: RTL and testbench



---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_scoreboard.sv | 41 ++++
 rtl/reg_file_2r1w.sv | 99 +++++++++
 tb/tb_reg_file_2r1w.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants, writeback bus type and address-legality helper for the register file.
// No timing of its own.
// No flow control.
package rf_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 8;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  // Writeback bus from the ALU at the default register-file geometry.
  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

  // An address names a real, writable/lockable register.
  function automatic logic rf_addr_legal(input int unsigned addr,
                                         input int unsigned num_regs,
                                         input logic        zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by lock, cleared by legal writeback, looked up per read port.
// Pending lookups are combinational; updates take effect at the next clock edge.
// No backpressure; a lock in the same cycle as a clear of that register wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic              pend_a,
  output logic              pend_b
);

  logic [NUM_REGS-1:0] pending;
  logic                lock_ok;

  assign lock_ok = lock_en && rf_addr_legal(32'(lock_addr), NUM_REGS, ZERO_REG);

  // clr_en only arrives for legal addresses; the lock is applied last so a newer producer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (clr_en)  pending[clr_addr]  <= 1'b0;
      if (lock_ok) pending[lock_addr] <= 1'b1;
    end
  end

  assign pend_a = rf_addr_legal(32'(raddr_a), NUM_REGS, ZERO_REG) && pending[raddr_a];
  assign pend_b = rf_addr_legal(32'(raddr_b), NUM_REGS, ZERO_REG) && pending[raddr_b];

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read one-write register file with optional write bypass and per-register scoreboard.
// Read latency 0 (READ_REG=0) or 1 (READ_REG=1); busy flags are always combinational.
// No backpressure; decode must stall on busy_a/busy_b itself.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic              busy_a,
  output logic              busy_b
);

  logic              wr_ok;
  logic [DATA_W-1:0] mem    [NUM_REGS];
  logic [ADDR_W-1:0] raddr  [2];
  logic [DATA_W-1:0] rd_sel [2];
  logic [DATA_W-1:0] rd_q   [2];
  logic [1:0]        fwd;
  logic [1:0]        pend;

  assign wr_ok    = we && rf_addr_legal(32'(waddr), NUM_REGS, ZERO_REG);
  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // A forward can only match a legal address, since wr_ok already requires one.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd[p]    = BYPASS && wr_ok && (waddr == raddr[p]);
      rd_sel[p] = '0;
      if (rf_addr_legal(32'(raddr[p]), NUM_REGS, ZERO_REG)) begin
        rd_sel[p] = fwd[p] ? wdata : mem[raddr[p]];
      end
    end
  end

  if (READ_REG) begin : g_rd_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q[0] <= '0;
        rd_q[1] <= '0;
      end else begin
        rd_q[0] <= rd_sel[0];
        rd_q[1] <= rd_sel[1];
      end
    end
  end else begin : g_rd_comb
    assign rd_q[0] = rd_sel[0];
    assign rd_q[1] = rd_sel[1];
  end

  assign rdata_a = rd_q[0];
  assign rdata_b = rd_q[1];

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .clr_en    (wr_ok),
    .clr_addr  (waddr),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .pend_a    (pend[0]),
    .pend_b    (pend[1])
  );

  // An operand being written back this cycle is forwarded, so it is not busy.
  assign busy_a = pend[0] && !fwd[0];
  assign busy_b = pend[1] && !fwd[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: four configurations (comb/registered read x bypass on/off) share one stimulus.
// Hand-written vector table for the corner cases, then a sweep and random traffic against an array model.
module tb_reg_file_2r1w;

  logic       clk = 1'b0;
  logic       rst, we, lock_en;
  logic [2:0] waddr, raddr_a, raddr_b, lock_addr;
  logic [7:0] wdata;

  // Index k: 0 = comb+bypass, 1 = comb no bypass, 2 = registered+bypass, 3 = registered no bypass
  logic [3:0][7:0] rda, rdb;
  logic [3:0]      bsa, bsb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.BYPASS(1'b1), .READ_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rda[0]), .raddr_b(raddr_b), .rdata_b(rdb[0]),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy_a(bsa[0]), .busy_b(bsb[0]));
  reg_file_2r1w #(.BYPASS(1'b0), .READ_REG(1'b0)) dut1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rda[1]), .raddr_b(raddr_b), .rdata_b(rdb[1]),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy_a(bsa[1]), .busy_b(bsb[1]));
  reg_file_2r1w #(.BYPASS(1'b1), .READ_REG(1'b1)) dut2 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rda[2]), .raddr_b(raddr_b), .rdata_b(rdb[2]),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy_a(bsa[2]), .busy_b(bsb[2]));
  reg_file_2r1w #(.BYPASS(1'b0), .READ_REG(1'b1)) dut3 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rda[3]), .raddr_b(raddr_b), .rdata_b(rdb[3]),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy_a(bsa[3]), .busy_b(bsb[3]));

  // Reference model: register contents, pending flags, and last registered read per configuration.
  logic [7:0] m_mem [8];
  bit         m_pend [8];
  logic [7:0] m_ra [4];
  logic [7:0] m_rb [4];

  function automatic bit cfg_bp(input int k);
    return (k == 0) || (k == 2);
  endfunction

  function automatic bit legal(input int a);
    return (a > 0) && (a < 8);
  endfunction

  function automatic bit fwd_hit(input int a, input bit bp);
    return bp && we && legal(int'(waddr)) && (int'(waddr) == a);
  endfunction

  function automatic logic [7:0] exp_rd(input int a, input bit bp);
    if (!legal(a)) return 8'h00;
    if (fwd_hit(a, bp)) return wdata;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input int a, input bit bp);
    return legal(a) && m_pend[a] && !fwd_hit(a, bp);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 4; k++) begin
      if (k < 2) begin
        chk($sformatf("model d%0d rdata_a", k), rda[k], exp_rd(int'(raddr_a), cfg_bp(k)));
        chk($sformatf("model d%0d rdata_b", k), rdb[k], exp_rd(int'(raddr_b), cfg_bp(k)));
      end else begin
        chk($sformatf("model d%0d rdata_a", k), rda[k], m_ra[k]);
        chk($sformatf("model d%0d rdata_b", k), rdb[k], m_rb[k]);
      end
      chk($sformatf("model d%0d busy_a", k), {7'b0, bsa[k]}, {7'b0, exp_busy(int'(raddr_a), cfg_bp(k))});
      chk($sformatf("model d%0d busy_b", k), {7'b0, bsb[k]}, {7'b0, exp_busy(int'(raddr_b), cfg_bp(k))});
    end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i]  = 8'h00;
        m_pend[i] = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        m_ra[k] = 8'h00;
        m_rb[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_ra[k] = exp_rd(int'(raddr_a), cfg_bp(k));
        m_rb[k] = exp_rd(int'(raddr_b), cfg_bp(k));
      end
      if (we && legal(int'(waddr))) begin
        m_mem[waddr]  = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (lock_en && legal(int'(lock_addr))) m_pend[lock_addr] = 1'b1;
    end
  endtask

  // Inputs are already applied; check before the edge, then clock model and DUT together.
  task automatic finish_cycle();
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic drive(input bit r, input bit w, input int wa, input int wd,
                       input int ra, input int rb, input bit lk, input int la);
    rst = r; we = w; waddr = 3'(wa); wdata = 8'(wd);
    raddr_a = 3'(ra); raddr_b = 3'(rb); lock_en = lk; lock_addr = 3'(la);
  endtask

  typedef struct {
    bit r, w;  int wa, wd, ra, rb;  bit lk;  int la;
    int e_a, e_a_nb, e_b;  bit e_bb;  int e_rr, e_rr_nb;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input bit r, input bit w, input int wa, input int wd,
                              input int ra, input int rb, input bit lk, input int la,
                              input int ea, input int eanb, input int eb, input bit ebb,
                              input int err, input int errnb);
    vec_t v;
    v.r = r; v.w = w; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.lk = lk; v.la = la;
    v.e_a = ea; v.e_a_nb = eanb; v.e_b = eb; v.e_bb = ebb; v.e_rr = err; v.e_rr_nb = errnb;
    return v;
  endfunction

  initial begin
    // rst we wa wd ra rb lk la | rdata_a(byp) rdata_a(no byp) rdata_b(byp) busy_b | reg rdata_a(byp) reg rdata_a(no byp)
    tbl[0]  = mk(1, 1, 1, 'h11, 2, 2, 1, 2,  'h00, 'h00, 'h00, 0,  'h00, 'h00);
    tbl[1]  = mk(0, 1, 3, 'h5C, 3, 1, 0, 0,  'h5C, 'h00, 'h00, 0,  'h00, 'h00);
    tbl[2]  = mk(0, 1, 0, 'hAA, 0, 3, 0, 0,  'h00, 'h00, 'h5C, 0,  'h5C, 'h00);
    tbl[3]  = mk(0, 0, 0, 'h00, 0, 5, 1, 5,  'h00, 'h00, 'h00, 0,  'h00, 'h00);
    tbl[4]  = mk(0, 0, 0, 'h00, 5, 5, 0, 0,  'h00, 'h00, 'h00, 1,  'h00, 'h00);
    tbl[5]  = mk(0, 0, 0, 'h00, 5, 5, 0, 0,  'h00, 'h00, 'h00, 1,  'h00, 'h00);
    tbl[6]  = mk(0, 1, 5, 'h7F, 5, 5, 0, 0,  'h7F, 'h00, 'h7F, 0,  'h00, 'h00);
    tbl[7]  = mk(0, 0, 0, 'h00, 5, 5, 0, 0,  'h7F, 'h7F, 'h7F, 0,  'h7F, 'h00);
    tbl[8]  = mk(0, 1, 6, 'h66, 6, 6, 1, 6,  'h66, 'h00, 'h66, 0,  'h7F, 'h7F);
    tbl[9]  = mk(0, 0, 0, 'h00, 6, 6, 0, 0,  'h66, 'h66, 'h66, 1,  'h66, 'h00);
    tbl[10] = mk(0, 0, 0, 'h00, 0, 0, 1, 0,  'h00, 'h00, 'h00, 0,  'h66, 'h66);
    tbl[11] = mk(0, 0, 0, 'h00, 0, 0, 0, 0,  'h00, 'h00, 'h00, 0,  'h00, 'h00);
    tbl[12] = mk(0, 1, 1, 'h99, 1, 2, 1, 2,  'h99, 'h00, 'h00, 0,  'h00, 'h00);
    tbl[13] = mk(1, 0, 0, 'h00, 1, 2, 0, 0,  'h99, 'h99, 'h00, 1,  'h99, 'h00);
    tbl[14] = mk(0, 0, 0, 'h00, 1, 2, 0, 0,  'h00, 'h00, 'h00, 0,  'h00, 'h00);
    tbl[15] = mk(0, 1, 4, 'h21, 4, 4, 0, 0,  'h21, 'h00, 'h21, 0,  'h00, 'h00);
    tbl[16] = mk(0, 0, 0, 'h00, 4, 4, 0, 0,  'h21, 'h21, 'h21, 0,  'h21, 'h00);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) begin
      @(posedge clk);
      model_update();
      #1;
    end

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, tbl[i].lk, tbl[i].la);
      @(negedge clk);
      chk($sformatf("vec%0d rdata_a byp", i),     rda[0], 8'(tbl[i].e_a));
      chk($sformatf("vec%0d rdata_a nobyp", i),   rda[1], 8'(tbl[i].e_a_nb));
      chk($sformatf("vec%0d rdata_b byp", i),     rdb[0], 8'(tbl[i].e_b));
      chk($sformatf("vec%0d busy_b byp", i),      {7'b0, bsb[0]}, {7'b0, tbl[i].e_bb});
      chk($sformatf("vec%0d reg rdata_a byp", i), rda[2], 8'(tbl[i].e_rr));
      chk($sformatf("vec%0d reg rdata_a nobyp", i), rda[3], 8'(tbl[i].e_rr_nb));
      finish_cycle();
    end

    // Sweep every data value through regs 1..7; address 0 gets 0xAA and must keep reading 0.
    for (int j = 0; j < 256; j++) begin
      for (int r = 0; r < 8; r++) begin
        drive(0, 1, r, (r == 0) ? 'hAA : j, r, (r + 7) % 8, 0, 0);
        step();
      end
      for (int r = 0; r < 8; r++) begin
        drive(0, 0, 0, 0, r, 7 - r, 0, 0);
        @(negedge clk);
        chk($sformatf("sweep j=%0d r%0d", j, r), rda[1], (r == 0) ? 8'h00 : 8'(j));
        finish_cycle();
      end
    end

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
